fetch_unit_128x8: RTL

Instruction fetch unit sitting between the control unit and the 128x8 synchronous program ROM. It drives the ROM address and absorbs the ROM's one-cycle registered read latency. It assembles one- or two-byte instructions (opcode plus optional operand) and presents each to the control unit over a valid/ready handshake. Branch redirects come in from the control unit. Out-of-range program addresses raise a sticky fault.

---
 rtl/fetch_unit_128x8.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit_128x8.sv
// Instruction fetch unit for a 128x8 synchronous program ROM: absorbs the ROM read
// latency, assembles one/two-byte instructions, handles branch redirects and range faults.
module fetch_unit_128x8 #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int         ROM_DEPTH = 128
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rom_address,
    input  logic [7:0] rom_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic       has_operand,
    output logic       illegal,
    output logic [7:0] pc,
    input  logic       branch_valid,
    input  logic [7:0] branch_target,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_ADDR_OP,
        S_DATA_OP,
        S_DATA_ARG,
        S_HOLD,
        S_FAULT
    } state_t;

    // Nine bits so that a full 256-entry depth still compares correctly.
    localparam logic [8:0] DEPTH = 9'(ROM_DEPTH);

    state_t     state, state_next;
    logic [7:0] pc_next;
    logic [7:0] opcode_next;
    logic [7:0] operand_next;
    logic       has_operand_next;
    logic       illegal_next;
    logic       instr_valid_next;
    logic       fault_next;

    logic       dec_two;
    logic       dec_illegal;
    logic       pc_out_of_range;
    logic       arg_out_of_range;
    logic       target_in_range;
    logic [7:0] pc_inc;

    // Length decode of the byte currently on rom_data (meaningful in S_DATA_OP).
    always_comb begin
        dec_two     = 1'b0;
        dec_illegal = 1'b0;
        if (rom_data inside {[8'h86:8'h89], 8'h96, 8'h97, [8'h20:8'h28]}) begin
            dec_two = 1'b1;
        end else if (!(rom_data inside {[8'h42:8'h4C]})) begin
            dec_illegal = 1'b1;
        end
    end

    assign pc_out_of_range  = ({1'b0, pc} >= DEPTH);
    assign arg_out_of_range = (({1'b0, pc} + 9'd1) >= DEPTH);
    assign target_in_range  = ({1'b0, branch_target} < DEPTH);
    assign pc_inc           = pc + 8'd1 + {7'd0, has_operand};

    always_comb begin
        rom_address = pc;
        if (!reset) begin
            rom_address = RESET_PC;
        end else if (state == S_DATA_OP && dec_two) begin
            rom_address = pc + 8'd1;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_next       = state;
        pc_next          = pc;
        opcode_next      = opcode;
        operand_next     = operand;
        has_operand_next = has_operand;
        illegal_next     = illegal;
        instr_valid_next = instr_valid;
        fault_next       = fault;

        unique case (state)
            S_ADDR_OP: begin
                if (pc_out_of_range) begin
                    state_next = S_FAULT;
                    fault_next = 1'b1;
                end else begin
                    state_next = S_DATA_OP;
                end
            end
            S_DATA_OP: begin
                opcode_next      = rom_data;
                illegal_next     = dec_illegal;
                has_operand_next = dec_two;
                if (dec_two) begin
                    if (arg_out_of_range) begin
                        state_next = S_FAULT;
                        fault_next = 1'b1;
                    end else begin
                        state_next = S_DATA_ARG;
                    end
                end else begin
                    operand_next     = 8'h00;
                    instr_valid_next = 1'b1;
                    state_next       = S_HOLD;
                end
            end
            S_DATA_ARG: begin
                operand_next     = rom_data;
                instr_valid_next = 1'b1;
                state_next       = S_HOLD;
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_next          = pc_inc;
                    instr_valid_next = 1'b0;
                    state_next       = S_ADDR_OP;
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_ADDR_OP;
            end
        endcase

        // A redirect overrides whatever the fetch sequence decided, including a
        // handshake in the same cycle (the instruction still counts as consumed).
        if (branch_valid) begin
            pc_next          = branch_target;
            state_next       = S_ADDR_OP;
            instr_valid_next = 1'b0;
            fault_next       = target_in_range ? 1'b0 : fault;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_ADDR_OP;
            pc          <= RESET_PC;
            opcode      <= 8'h00;
            operand     <= 8'h00;
            has_operand <= 1'b0;
            illegal     <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            opcode      <= opcode_next;
            operand     <= operand_next;
            has_operand <= has_operand_next;
            illegal     <= illegal_next;
            instr_valid <= instr_valid_next;
            fault       <= fault_next;
        end
    end

endmodule
